// File: rtl/gpu_pkg.sv
// Shared definitions for the triangle setup stage.
//   - screen limits used for bounding-box clamping
//   - coefficient / area / reciprocal widths
//   - setup FSM state enum
//   - edge-equation and clamp helper functions
package gpu_pkg;

    localparam int SCREEN_W   = 320;
    localparam int SCREEN_H   = 240;
    localparam int INV_SHIFT  = 24;
    localparam int DIV_CYCLES = INV_SHIFT + 1;

    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int Z_W     = 16;
    localparam int COLOR_W = 8;
    localparam int A_W     = 9;
    localparam int B_W     = 9;
    localparam int C_W     = 18;
    localparam int AREA_W  = 19;
    localparam int INV_W   = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EDGE,
        S_CSUM,
        S_ORIENT,
        S_DIV,
        S_LAUNCH,
        S_WAIT_DONE
    } setup_state_t;

    // A = ya - yb; fits 9-bit signed since y is 8-bit unsigned.
    function automatic logic signed [A_W-1:0] edge_a(input logic [Y_W-1:0] ya,
                                                     input logic [Y_W-1:0] yb);
        return $signed({1'b0, ya}) - $signed({1'b0, yb});
    endfunction

    // B = xb - xa, one bit wider than the output so range overflow is visible.
    function automatic logic signed [B_W:0] edge_b(input logic [X_W-1:0] xa,
                                                   input logic [X_W-1:0] xb);
        return $signed({1'b0, xb}) - $signed({1'b0, xa});
    endfunction

    // C = xa*yb - xb*ya; each product is below 2^17, so the difference is
    // exact in 18-bit two's complement.
    function automatic logic signed [C_W-1:0] edge_c(input logic [X_W-1:0] xa,
                                                     input logic [Y_W-1:0] ya,
                                                     input logic [X_W-1:0] xb,
                                                     input logic [Y_W-1:0] yb);
        logic [C_W-1:0] p_ab;
        logic [C_W-1:0] p_ba;
        p_ab = C_W'(xa) * C_W'(yb);
        p_ba = C_W'(xb) * C_W'(ya);
        return $signed(p_ab - p_ba);
    endfunction

    function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] x);
        return (x > X_W'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : x;
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] y);
        return (y > Y_W'(SCREEN_H - 1)) ? Y_W'(SCREEN_H - 1) : y;
    endfunction

endpackage

// File: rtl/triangle_setup_if.sv
// Triangle setup bus: upstream triangle handshake, setup results and the
// rasterizer launch/done pair.
//   master : environment side (drives tri_*, rasterizer_done)
//   slave  : setup block side (drives tri_ready, coefficients, bbox,
//            inv_area, z/color, rasterizer_start, tri_dropped)
interface triangle_setup_if;
    import gpu_pkg::*;

    logic                     tri_valid;
    logic                     tri_ready;
    logic [X_W-1:0]           tri_x1, tri_x2, tri_x3;
    logic [Y_W-1:0]           tri_y1, tri_y2, tri_y3;
    logic [Z_W-1:0]           tri_z1, tri_z2, tri_z3;
    logic [COLOR_W-1:0]       tri_color;
    logic signed [A_W-1:0]    a1, a2, a3;
    logic signed [B_W-1:0]    b1, b2, b3;
    logic signed [C_W-1:0]    c1, c2, c3;
    logic [X_W-1:0]           bbxi, bbxf;
    logic [Y_W-1:0]           bbyi, bbyf;
    logic [INV_W-1:0]         inv_area;
    logic [Z_W-1:0]           z1, z2, z3;
    logic [COLOR_W-1:0]       color;
    logic                     rasterizer_start;
    logic                     rasterizer_done;
    logic                     tri_dropped;

    modport master (
        output tri_valid, tri_x1, tri_x2, tri_x3, tri_y1, tri_y2, tri_y3,
               tri_z1, tri_z2, tri_z3, tri_color, rasterizer_done,
        input  tri_ready, a1, b1, c1, a2, b2, c2, a3, b3, c3,
               bbxi, bbxf, bbyi, bbyf, inv_area, z1, z2, z3, color,
               rasterizer_start, tri_dropped
    );

    modport slave (
        input  tri_valid, tri_x1, tri_x2, tri_x3, tri_y1, tri_y2, tri_y3,
               tri_z1, tri_z2, tri_z3, tri_color, rasterizer_done,
        output tri_ready, a1, b1, c1, a2, b2, c2, a3, b3, c3,
               bbxi, bbxf, bbyi, bbyf, inv_area, z1, z2, z3, color,
               rasterizer_start, tri_dropped
    );

endinterface

// File: rtl/recip_divider.sv
// Iterative unsigned restoring divider computing floor(2^INV_SHIFT / divisor).
// One quotient bit per cycle, MSB first, DIV_CYCLES cycles after start.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load divisor and begin
//   divisor   : unsigned, must be non-zero
//   busy      : iteration in progress
//   done      : high during the final iteration cycle (quotient complete
//               after that edge)
//   quotient  : result; upper bits above INV_SHIFT stay 0
module recip_divider
    import gpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AREA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [INV_W-1:0]  quotient
);

    logic [AREA_W-1:0] dvs_q;
    logic [AREA_W:0]   rem_q;
    logic [AREA_W:0]   rem_shift;
    logic [4:0]        bit_idx;
    logic              fits;

    // The dividend is a single 1 at bit INV_SHIFT, so its bits are generated
    // on the fly instead of being stored.
    assign rem_shift = {rem_q[AREA_W-1:0], (bit_idx == 5'(INV_SHIFT))};
    assign fits      = (rem_shift >= {1'b0, dvs_q});
    assign done      = busy && (bit_idx == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            dvs_q    <= '0;
            rem_q    <= '0;
            bit_idx  <= '0;
            quotient <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            dvs_q    <= divisor;
            rem_q    <= '0;
            bit_idx  <= 5'(DIV_CYCLES - 1);
            quotient <= '0;
        end else if (busy) begin
            rem_q    <= fits ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
            quotient <= {quotient[INV_W-2:0], fits};
            if (bit_idx == 5'd0) begin
                busy <= 1'b0;
            end else begin
                bit_idx <= bit_idx - 5'd1;
            end
        end
    end

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup stage feeding the rasterizer: latches one triangle, forms
// the three edge equations, clamped bounding box and fixed-point inverse
// of twice the area, launches the rasterizer and holds results until done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : triangle_setup_if slave (triangle in, setup results out,
//              rasterizer launch/done, drop pulse)
//
// state       | meaning
// S_IDLE      | tri_ready=1, waiting for a triangle
// S_EDGE      | edge coefficients A, B, C
// S_CSUM      | area2 = c1+c2+c3, bounding box
// S_ORIENT    | drop degenerate/oversize, flip clockwise to positive area
// S_DIV       | reciprocal of area2 (25 cycles)
// S_LAUNCH    | single-cycle rasterizer_start
// S_WAIT_DONE | outputs frozen until rasterizer_done
module triangle_setup
    import gpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    triangle_setup_if.slave bus
);

    setup_state_t state_q, state_d;

    logic [X_W-1:0]         x1_q, x2_q, x3_q;
    logic [Y_W-1:0]         y1_q, y2_q, y3_q;
    logic [Z_W-1:0]         z1_q, z2_q, z3_q;
    logic [COLOR_W-1:0]     color_q;
    logic signed [A_W-1:0]  a_q [3];
    logic signed [B_W-1:0]  b_q [3];
    logic signed [C_W-1:0]  c_q [3];
    logic signed [A_W-1:0]  a_w [3];
    logic signed [B_W:0]    b_w [3];
    logic signed [C_W-1:0]  c_w [3];
    logic                   b_oob_q;
    logic signed [AREA_W-1:0] area_q;
    logic [AREA_W-1:0]      area_abs;
    logic [X_W-1:0]         x_lo, x_hi, bbxi_q, bbxf_q;
    logic [Y_W-1:0]         y_lo, y_hi, bbyi_q, bbyf_q;
    logic                   div_start, div_busy, div_done;
    logic [INV_W-1:0]       quotient;
    logic                   start_pulse, drop_pulse;

    // Edge k is opposite vertex k: E1 v2->v3, E2 v3->v1, E3 v1->v2.
    assign a_w[0] = edge_a(y2_q, y3_q);
    assign b_w[0] = edge_b(x2_q, x3_q);
    assign c_w[0] = edge_c(x2_q, y2_q, x3_q, y3_q);
    assign a_w[1] = edge_a(y3_q, y1_q);
    assign b_w[1] = edge_b(x3_q, x1_q);
    assign c_w[1] = edge_c(x3_q, y3_q, x1_q, y1_q);
    assign a_w[2] = edge_a(y1_q, y2_q);
    assign b_w[2] = edge_b(x1_q, x2_q);
    assign c_w[2] = edge_c(x1_q, y1_q, x2_q, y2_q);

    assign area_abs = area_q[AREA_W-1] ? $unsigned(-area_q) : $unsigned(area_q);

    always_comb begin
        x_lo = x1_q;
        x_hi = x1_q;
        y_lo = y1_q;
        y_hi = y1_q;
        if (x2_q < x_lo) x_lo = x2_q;
        if (x3_q < x_lo) x_lo = x3_q;
        if (x2_q > x_hi) x_hi = x2_q;
        if (x3_q > x_hi) x_hi = x3_q;
        if (y2_q < y_lo) y_lo = y2_q;
        if (y3_q < y_lo) y_lo = y3_q;
        if (y2_q > y_hi) y_hi = y2_q;
        if (y3_q > y_hi) y_hi = y3_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_start   = 1'b0;
        start_pulse = 1'b0;
        drop_pulse  = 1'b0;
        case (state_q)
            S_IDLE:   if (bus.tri_valid) state_d = S_EDGE;
            S_EDGE:   state_d = S_CSUM;
            S_CSUM:   state_d = S_ORIENT;
            S_ORIENT: begin
                if (area_q == '0 || b_oob_q) begin
                    drop_pulse = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    div_start = 1'b1;
                    state_d   = S_DIV;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    state_d = S_LAUNCH;
                end else if (!div_busy) begin
                    // Divider idle without finishing: recover instead of hanging.
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                start_pulse = 1'b1;
                state_d     = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (bus.rasterizer_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {x1_q, x2_q, x3_q} <= '0;
            {y1_q, y2_q, y3_q} <= '0;
            {z1_q, z2_q, z3_q} <= '0;
            color_q <= '0;
            for (int k = 0; k < 3; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= '0;
            end
            b_oob_q <= 1'b0;
            area_q  <= '0;
            bbxi_q  <= '0;
            bbxf_q  <= '0;
            bbyi_q  <= '0;
            bbyf_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.tri_valid) begin
                        x1_q <= bus.tri_x1;
                        x2_q <= bus.tri_x2;
                        x3_q <= bus.tri_x3;
                        y1_q <= bus.tri_y1;
                        y2_q <= bus.tri_y2;
                        y3_q <= bus.tri_y3;
                        z1_q <= bus.tri_z1;
                        z2_q <= bus.tri_z2;
                        z3_q <= bus.tri_z3;
                        color_q <= bus.tri_color;
                    end
                end
                S_EDGE: begin
                    for (int k = 0; k < 3; k++) begin
                        a_q[k] <= a_w[k];
                        b_q[k] <= b_w[k][B_W-1:0];
                        c_q[k] <= c_w[k];
                    end
                    // B outside -256..255 shows up as the top two bits differing.
                    b_oob_q <= (b_w[0][B_W] != b_w[0][B_W-1]) ||
                               (b_w[1][B_W] != b_w[1][B_W-1]) ||
                               (b_w[2][B_W] != b_w[2][B_W-1]);
                end
                S_CSUM: begin
                    area_q <= AREA_W'(c_q[0]) + AREA_W'(c_q[1]) + AREA_W'(c_q[2]);
                    bbxi_q <= clamp_x(x_lo);
                    bbxf_q <= clamp_x(x_hi);
                    bbyi_q <= clamp_y(y_lo);
                    bbyf_q <= clamp_y(y_hi);
                end
                S_ORIENT: begin
                    // Clockwise input: flip so interior pixels evaluate >= 0.
                    if (area_q[AREA_W-1]) begin
                        for (int k = 0; k < 3; k++) begin
                            a_q[k] <= -a_q[k];
                            b_q[k] <= -b_q[k];
                            c_q[k] <= -c_q[k];
                        end
                        area_q <= -area_q;
                    end
                end
                default: ;
            endcase
        end
    end

    recip_divider u_recip (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .divisor  (area_abs),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    assign bus.tri_ready        = (state_q == S_IDLE);
    assign bus.rasterizer_start = start_pulse;
    assign bus.tri_dropped      = drop_pulse;
    assign bus.a1 = a_q[0];
    assign bus.b1 = b_q[0];
    assign bus.c1 = c_q[0];
    assign bus.a2 = a_q[1];
    assign bus.b2 = b_q[1];
    assign bus.c2 = c_q[1];
    assign bus.a3 = a_q[2];
    assign bus.b3 = b_q[2];
    assign bus.c3 = c_q[2];
    assign bus.bbxi     = bbxi_q;
    assign bus.bbxf     = bbxf_q;
    assign bus.bbyi     = bbyi_q;
    assign bus.bbyf     = bbyf_q;
    assign bus.inv_area = quotient;
    assign bus.z1       = z1_q;
    assign bus.z2       = z2_q;
    assign bus.z3       = z3_q;
    assign bus.color    = color_q;

endmodule

// File: tb/tb_triangle_setup.sv
// Directed testbench for triangle_setup: hand-computed edge coefficients,
// bounding boxes, inverse areas, launch latency, drops, backpressure and
// mid-divide reset.
module tb_triangle_setup;
    import gpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk = ~clk;

    triangle_setup_if bus ();

    triangle_setup dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_tri(input int x1, input int y1, input int x2, input int y2,
                            input int x3, input int y3, input int z, input int col);
        bus.tri_x1    = X_W'(x1);
        bus.tri_y1    = Y_W'(y1);
        bus.tri_x2    = X_W'(x2);
        bus.tri_y2    = Y_W'(y2);
        bus.tri_x3    = X_W'(x3);
        bus.tri_y3    = Y_W'(y3);
        bus.tri_z1    = Z_W'(z);
        bus.tri_z2    = Z_W'(z + 1);
        bus.tri_z3    = Z_W'(z + 2);
        bus.tri_color = COLOR_W'(col);
    endtask

    // Present the loaded triangle, transfer on the next edge, then watch
    // cycles 1..32 after the transfer edge.
    task automatic track(output int start_cyc, output int drop_cyc,
                         output int start_cnt, output int rdy_after_drop);
        start_cyc      = -1;
        drop_cyc       = -1;
        start_cnt      = 0;
        rdy_after_drop = -1;
        bus.tri_valid  = 1'b1;
        @(posedge clk); #1;
        bus.tri_valid  = 1'b0;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            if (bus.rasterizer_start) begin
                start_cnt++;
                if (start_cyc < 0) start_cyc = cyc;
            end
            if (bus.tri_dropped && drop_cyc < 0) drop_cyc = cyc;
            if (drop_cyc >= 0 && cyc == drop_cyc + 1) rdy_after_drop = int'(bus.tri_ready);
            if (cyc < 32) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_coef(input string t,
                              input int ea1, input int eb1, input int ec1,
                              input int ea2, input int eb2, input int ec2,
                              input int ea3, input int eb3, input int ec3);
        chk({t, ".a1"}, int'(bus.a1), ea1);
        chk({t, ".b1"}, int'(bus.b1), eb1);
        chk({t, ".c1"}, int'(bus.c1), ec1);
        chk({t, ".a2"}, int'(bus.a2), ea2);
        chk({t, ".b2"}, int'(bus.b2), eb2);
        chk({t, ".c2"}, int'(bus.c2), ec2);
        chk({t, ".a3"}, int'(bus.a3), ea3);
        chk({t, ".b3"}, int'(bus.b3), eb3);
        chk({t, ".c3"}, int'(bus.c3), ec3);
    endtask

    task automatic check_box(input string t, input int xi, input int xf,
                             input int yi, input int yf);
        chk({t, ".bbxi"}, int'(bus.bbxi), xi);
        chk({t, ".bbxf"}, int'(bus.bbxf), xf);
        chk({t, ".bbyi"}, int'(bus.bbyi), yi);
        chk({t, ".bbyf"}, int'(bus.bbyf), yf);
    endtask

    task automatic raster_done(input string t);
        bus.rasterizer_done = 1'b1;
        @(posedge clk); #1;
        bus.rasterizer_done = 1'b0;
        chk({t, ".ready_after_done"}, int'(bus.tri_ready), 1);
    endtask

    task automatic check_zero_outputs(input string t);
        chk({t, ".ready"}, int'(bus.tri_ready), 1);
        chk({t, ".start"}, int'(bus.rasterizer_start), 0);
        chk({t, ".dropped"}, int'(bus.tri_dropped), 0);
        check_coef(t, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_box(t, 0, 0, 0, 0);
        chk({t, ".inv_area"}, int'(bus.inv_area), 0);
        chk({t, ".z1"}, int'(bus.z1), 0);
        chk({t, ".z3"}, int'(bus.z3), 0);
        chk({t, ".color"}, int'(bus.color), 0);
    endtask

    initial begin
        int sc, dc, scnt, rdy, seen;

        bus.tri_valid       = 1'b0;
        bus.rasterizer_done = 1'b0;
        load_tri(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_zero_outputs("reset");

        // Counter-clockwise reference triangle.
        load_tri(10, 10, 20, 10, 10, 20, 100, 8'h5A);
        track(sc, dc, scnt, rdy);
        chk("ccw.start_cycle", sc, 29);
        chk("ccw.start_count", scnt, 1);
        chk("ccw.drop_cycle", dc, -1);
        check_coef("ccw", -10, -10, 300, 10, 0, -100, 0, 10, -100);
        check_box("ccw", 10, 20, 10, 20);
        chk("ccw.inv_area", int'(bus.inv_area), 167772);
        chk("ccw.z1", int'(bus.z1), 100);
        chk("ccw.z2", int'(bus.z2), 101);
        chk("ccw.z3", int'(bus.z3), 102);
        chk("ccw.color", int'(bus.color), 8'h5A);
        chk("ccw.ready_wait", int'(bus.tri_ready), 0);
        raster_done("ccw");

        // Same triangle, clockwise: flipped into positive orientation.
        load_tri(10, 10, 10, 20, 20, 10, 200, 8'h11);
        track(sc, dc, scnt, rdy);
        chk("cw.start_cycle", sc, 29);
        check_coef("cw", -10, -10, 300, 0, 10, -100, 10, 0, -100);
        chk("cw.inv_area", int'(bus.inv_area), 167772);
        raster_done("cw");

        // Collinear: zero area.
        load_tri(0, 0, 10, 10, 20, 20, 300, 8'h22);
        track(sc, dc, scnt, rdy);
        chk("collinear.drop_cycle", dc, 3);
        chk("collinear.start_count", scnt, 0);
        chk("collinear.ready_next", rdy, 1);

        // Oversize: |B| = 300 exceeds the 9-bit range.
        load_tri(0, 0, 300, 0, 0, 100, 400, 8'h33);
        track(sc, dc, scnt, rdy);
        chk("oversize.drop_cycle", dc, 3);
        chk("oversize.start_count", scnt, 0);
        chk("oversize.ready_next", rdy, 1);

        // Single-pixel triangle: area2 = 1.
        load_tri(0, 0, 1, 0, 0, 1, 500, 8'h44);
        track(sc, dc, scnt, rdy);
        chk("pixel.start_cycle", sc, 29);
        check_coef("pixel", -1, -1, 1, 1, 0, 0, 0, 1, 0);
        check_box("pixel", 0, 1, 0, 1);
        chk("pixel.inv_area", int'(bus.inv_area), 16777216);
        raster_done("pixel");

        // Backpressure: triangle offered while the previous one is rasterizing.
        load_tri(10, 10, 20, 10, 10, 20, 100, 8'h5A);
        track(sc, dc, scnt, rdy);
        chk("bp_first.start_cycle", sc, 29);
        load_tri(300, 230, 400, 230, 300, 250, 7000, 8'hC3);
        bus.tri_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus.tri_ready) seen++;
        end
        chk("bp.ready_cycles", seen, 0);
        chk("bp.hold_a1", int'(bus.a1), -10);
        chk("bp.hold_inv", int'(bus.inv_area), 167772);
        chk("bp.hold_color", int'(bus.color), 8'h5A);
        raster_done("bp_first");
        track(sc, dc, scnt, rdy);
        chk("clamp.start_cycle", sc, 29);
        check_coef("clamp", -20, -100, 31000, 20, 0, -6000, 0, 100, -23000);
        check_box("clamp", 300, 319, 230, 239);
        chk("clamp.inv_area", int'(bus.inv_area), 8388);
        chk("clamp.z1", int'(bus.z1), 7000);
        chk("clamp.z3", int'(bus.z3), 7002);
        chk("clamp.color", int'(bus.color), 8'hC3);
        raster_done("clamp");

        // Reset during the 10th divide cycle (cycle 13 after transfer).
        load_tri(10, 10, 20, 10, 10, 20, 100, 8'h5A);
        bus.tri_valid = 1'b1;
        @(posedge clk); #1;
        bus.tri_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero_outputs("div_reset");
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.rasterizer_start) seen++;
        end
        chk("div_reset.no_start", seen, 0);
        chk("div_reset.ready_idle", int'(bus.tri_ready), 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
